// File: rtl/tile_hash_streamer.sv
// Streams a captured 16-byte tile to a hash engine one byte per cycle, then returns the hash with the caller tag.
// Optional build macro TILE_STREAMER_TIMEOUT_EN adds a bounded wait for the hash return with an error result.
module tile_hash_streamer #(
  parameter int TAG_W          = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tile_valid,
  output logic             tile_ready,
  input  logic [127:0]     tile_data,
  input  logic [TAG_W-1:0] tile_tag,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  input  logic             byte_ready,
  input  logic             hash_valid,
  input  logic [15:0]      hash_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [15:0]      result_hash,
  output logic [TAG_W-1:0] result_tag,
  output logic             result_err
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_HASH, RESULT} stateT;

  stateT            r_state;
  stateT            w_nextState;
  logic [127:0]     r_tile;
  logic [TAG_W-1:0] r_tag;
  logic [3:0]       r_index;
  logic             r_byteValid;
  logic [7:0]       r_byteData;
  logic             r_byteLast;
  logic             r_resultValid;
  logic [15:0]      r_resultHash;
  logic [TAG_W-1:0] r_resultTag;
  logic             r_resultErr;

  logic [3:0]       w_nextIndex;
  logic [7:0]       w_nextByte;
  logic             w_byteAccept;
  logic             w_lastAccept;
  logic             w_timeout;

  assign tile_ready   = (r_state == IDLE);
  assign byte_valid   = r_byteValid;
  assign byte_data    = r_byteData;
  assign byte_last    = r_byteLast;
  assign result_valid = r_resultValid;
  assign result_hash  = r_resultHash;
  assign result_tag   = r_resultTag;
  assign result_err   = r_resultErr;

  // Byte 0 sits in the top bits, so the byte at index i starts at bit 8*(15-i).
  assign w_nextIndex  = r_index + 4'd1;
  assign w_nextByte   = r_tile[{4'd15 - w_nextIndex, 3'b000} +: 8];
  assign w_byteAccept = (r_state == STREAM) && r_byteValid && byte_ready;
  assign w_lastAccept = w_byteAccept && (r_index == 4'd15);

`ifdef TILE_STREAMER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] r_timeoutCount;

  // The count holds the number of elapsed hash-less wait cycles before this one.
  assign w_timeout = (r_state == WAIT_HASH) &&
                     (r_timeoutCount == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeoutCount <= '0;
    end else if (w_lastAccept) begin
      r_timeoutCount <= '0;
    end else if ((r_state == WAIT_HASH) && !hash_valid && !w_timeout) begin
      r_timeoutCount <= r_timeoutCount + 1'b1;
    end
  end
`else
  logic [31:0] w_unusedTimeoutCycles;

  assign w_unusedTimeoutCycles = 32'(TIMEOUT_CYCLES);
  assign w_timeout             = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (tile_valid) w_nextState = STREAM;
      STREAM:    if (w_lastAccept) w_nextState = WAIT_HASH;
      WAIT_HASH: if (hash_valid || w_timeout) w_nextState = RESULT;
      RESULT:    if (result_ready) w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // Datapath; a hash pulse takes priority over a timeout reached in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tile        <= '0;
      r_tag         <= '0;
      r_index       <= 4'd0;
      r_byteValid   <= 1'b0;
      r_byteData    <= 8'h00;
      r_byteLast    <= 1'b0;
      r_resultValid <= 1'b0;
      r_resultHash  <= 16'h0000;
      r_resultTag   <= '0;
      r_resultErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tile_valid) begin
            r_tile      <= tile_data;
            r_tag       <= tile_tag;
            r_index     <= 4'd0;
            r_byteValid <= 1'b1;
            r_byteData  <= tile_data[127:120];
            r_byteLast  <= 1'b0;
          end
        end
        STREAM: begin
          if (w_lastAccept) begin
            r_byteValid <= 1'b0;
            r_byteLast  <= 1'b0;
          end else if (w_byteAccept) begin
            r_index    <= w_nextIndex;
            r_byteData <= w_nextByte;
            r_byteLast <= (w_nextIndex == 4'd15);
          end
        end
        WAIT_HASH: begin
          if (hash_valid) begin
            r_resultValid <= 1'b1;
            r_resultHash  <= hash_in;
            r_resultTag   <= r_tag;
            r_resultErr   <= 1'b0;
          end else if (w_timeout) begin
            r_resultValid <= 1'b1;
            r_resultHash  <= 16'h0000;
            r_resultTag   <= r_tag;
            r_resultErr   <= 1'b1;
          end
        end
        RESULT: begin
          if (result_ready) r_resultValid <= 1'b0;
        end
        default: begin
          r_resultValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_hash_streamer.sv
// Directed self-checking bench for tile_hash_streamer; follows the timeout path when TILE_STREAMER_TIMEOUT_EN is defined.
module tb_tile_hash_streamer;

  localparam logic [127:0] TILE_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] TILE_B = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  logic         clk;
  logic         rst;
  logic         tile_valid;
  logic         tile_ready;
  logic [127:0] tile_data;
  logic [7:0]   tile_tag;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_last;
  logic         byte_ready;
  logic         hash_valid;
  logic [15:0]  hash_in;
  logic         result_valid;
  logic         result_ready;
  logic [15:0]  result_hash;
  logic [7:0]   result_tag;
  logic         result_err;

  int checks      = 0;
  int failures    = 0;
  int acceptCount = 0;

  tile_hash_streamer #(.TAG_W(8), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_data(tile_data), .tile_tag(tile_tag),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready),
    .hash_valid(hash_valid), .hash_in(hash_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_hash(result_hash), .result_tag(result_tag),
    .result_err(result_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] byteOf(input logic [127:0] d, input int k);
    return d[127 - 8*k -: 8];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic tv, input logic [127:0] td, input logic [7:0] tt,
                               input logic br, input logic rr);
    tile_valid   = tv;
    tile_data    = td;
    tile_tag     = tt;
    byte_ready   = br;
    result_ready = rr;
  endtask

  // Advance to the next falling edge, counting the byte handshake seen in the cycle just left.
  task automatic step();
    if (byte_valid && byte_ready) acceptCount++;
    @(negedge clk);
  endtask

  task automatic checkBytes(input logic [127:0] d, input int stallAt, input int pulseAt);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("byte_valid[%0d]", k), 32'(byte_valid), 32'd1);
      checkOutput($sformatf("byte_data[%0d]", k), 32'(byte_data), 32'(byteOf(d, k)));
      checkOutput($sformatf("byte_last[%0d]", k), 32'(byte_last), 32'(k == 15));
      if (k == stallAt) begin
        byte_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          step();
          checkOutput($sformatf("stall_valid[%0d]", s), 32'(byte_valid), 32'd1);
          checkOutput($sformatf("stall_data[%0d]", s), 32'(byte_data), 32'(byteOf(d, k)));
        end
        byte_ready = 1'b1;
      end
      if (k == pulseAt) begin
        hash_valid = 1'b1;
        hash_in    = 16'h1234;
      end
      step();
      hash_valid = 1'b0;
    end
    checkOutput("byte_valid_after_last", 32'(byte_valid), 32'd0);
    checkOutput("byte_last_after_last", 32'(byte_last), 32'd0);
  endtask

  task automatic checkResult(input string tag, input logic [15:0] h, input logic [7:0] t,
                             input logic e);
    checkOutput({tag, "_valid"}, 32'(result_valid), 32'd1);
    checkOutput({tag, "_hash"}, 32'(result_hash), 32'(h));
    checkOutput({tag, "_tag"}, 32'(result_tag), 32'(t));
    checkOutput({tag, "_err"}, 32'(result_err), 32'(e));
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    checkOutput("result_valid_after_hs", 32'(result_valid), 32'd0);
    checkOutput("tile_ready_after_hs", 32'(tile_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    hash_valid = 1'b0;
    hash_in    = 16'h0000;
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);
    step();
    $display("[TB] reset state");
    checkOutput("rst_tile_ready", 32'(tile_ready), 32'd1);
    checkOutput("rst_byte_valid", 32'(byte_valid), 32'd0);
    checkOutput("rst_byte_data", 32'(byte_data), 32'd0);
    checkOutput("rst_byte_last", 32'(byte_last), 32'd0);
    checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
    checkOutput("rst_result_hash", 32'(result_hash), 32'd0);
    checkOutput("rst_result_tag", 32'(result_tag), 32'd0);
    checkOutput("rst_result_err", 32'(result_err), 32'd0);

    // A tile offered while reset is held must not be captured.
    applyStimulus(1'b1, TILE_A, 8'hEE, 1'b1, 1'b0);
    step();
    step();
    checkOutput("rst_no_capture", 32'(byte_valid), 32'd0);
    checkOutput("rst_tile_ready_held", 32'(tile_ready), 32'd1);
    tile_valid = 1'b0;
    rst        = 1'b0;
    step();

    $display("[TB] hash pulse in IDLE is ignored");
    hash_valid = 1'b1;
    hash_in    = 16'h1234;
    step();
    hash_valid = 1'b0;
    checkOutput("idle_hash_ignored", 32'(result_valid), 32'd0);
    checkOutput("idle_tile_ready", 32'(tile_ready), 32'd1);

    $display("[TB] full-throughput tile with stray hash during STREAM");
    applyStimulus(1'b1, TILE_A, 8'h5A, 1'b1, 1'b0);
    step();
    tile_valid = 1'b0;
    checkOutput("stream_tile_ready", 32'(tile_ready), 32'd0);
    checkBytes(TILE_A, -1, 2);
    checkOutput("wait_no_result", 32'(result_valid), 32'd0);
    hash_valid = 1'b1;
    hash_in    = 16'hBEEF;
    step();
    hash_valid = 1'b0;
    checkResult("resA", 16'hBEEF, 8'h5A, 1'b0);
    step();
    checkResult("resA_hold", 16'hBEEF, 8'h5A, 1'b0);
    handshake();

    $display("[TB] backpressure on byte 3");
    acceptCount = 0;
    applyStimulus(1'b1, TILE_A, 8'h21, 1'b1, 1'b0);
    step();
    tile_valid = 1'b0;
    checkBytes(TILE_A, 3, -1);
    checkOutput("accepted_bytes", 32'(acceptCount), 32'd16);
    hash_valid = 1'b1;
    hash_in    = 16'hC0DE;
    step();
    hash_valid = 1'b0;
    checkResult("resB", 16'hC0DE, 8'h21, 1'b0);

    $display("[TB] result backpressure with second tile waiting");
    applyStimulus(1'b1, TILE_B, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkResult($sformatf("resB_stall%0d", i), 16'hC0DE, 8'h21, 1'b0);
      checkOutput($sformatf("stall_tile_ready%0d", i), 32'(tile_ready), 32'd0);
      checkOutput($sformatf("stall_no_byte%0d", i), 32'(byte_valid), 32'd0);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    checkOutput("hs_result_valid", 32'(result_valid), 32'd0);
    checkOutput("hs_tile_ready", 32'(tile_ready), 32'd1);
    checkOutput("hs_not_yet_captured", 32'(byte_valid), 32'd0);
    step();
    tile_valid = 1'b0;
    checkBytes(TILE_B, -1, -1);

`ifdef TILE_STREAMER_TIMEOUT_EN
    $display("[TB] hash timeout");
    for (int i = 0; i < 14; i++) begin
      step();
      checkOutput($sformatf("timeout_wait%0d", i), 32'(result_valid), 32'd0);
    end
    step();
    checkResult("resTimeout", 16'h0000, 8'h77, 1'b1);
`else
    $display("[TB] indefinite hash wait");
    repeat (100) step();
    checkOutput("wait100_result_valid", 32'(result_valid), 32'd0);
    checkOutput("wait100_tile_ready", 32'(tile_ready), 32'd0);
    checkOutput("wait100_byte_valid", 32'(byte_valid), 32'd0);
    hash_valid = 1'b1;
    hash_in    = 16'h5555;
    step();
    hash_valid = 1'b0;
    checkResult("resLate", 16'h5555, 8'h77, 1'b0);
`endif
    handshake();

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1'b1, TILE_A, 8'h5A, 1'b1, 1'b0);
    step();
    tile_valid = 1'b0;
    repeat (7) step();
    checkOutput("pre_rst_byte7", 32'(byte_data), 32'h77);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_byte_valid", 32'(byte_valid), 32'd0);
    checkOutput("async_rst_byte_data", 32'(byte_data), 32'd0);
    checkOutput("async_rst_tile_ready", 32'(tile_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();
    applyStimulus(1'b1, TILE_B, 8'h3C, 1'b1, 1'b0);
    step();
    tile_valid = 1'b0;
    checkBytes(TILE_B, -1, -1);
    hash_valid = 1'b1;
    hash_in    = 16'hA5A5;
    step();
    hash_valid = 1'b0;
    checkResult("resAfterRst", 16'hA5A5, 8'h3C, 1'b0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
